param_regfile: RTL and testbench

PARAM_REGFILE -- requirements
Module: param_regfile

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clr_seq.sv | 80 ++++++++
 rtl/param_regfile.sv | 79 +++++++
 tb/tb_param_regfile.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the parameterised
// register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every register index once, zeroing one entry per
// cycle, then signals completion with a single-cycle done pulse.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    clr_state_e        state_r;
    clr_state_e        state_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_s;
    logic              busy_r;
    logic              done_r;

    // Next-state and index update; DONE is reached by compare, never by wrap.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    state_s = CLEAR;
                    idx_s   = '0;
                end else begin
                    state_s = IDLE;
                    idx_s   = idx_r;
                end
            end
            CLEAR: begin
                if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                    idx_s   = idx_r;
                end else begin
                    state_s = CLEAR;
                    idx_s   = idx_r + ADDR_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                idx_s   = idx_r;
            end
            default: begin
                state_s = IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // State, index and status flags; flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    assign clr_busy = busy_r;
    assign clr_done = done_r;
    assign clr_we   = (state_r == CLEAR);
    assign clr_idx  = idx_r;

endmodule

// File: rtl/param_regfile.sv
// Parameterised multi-read-port register file with a hardwired zero register,
// optional write-to-read forwarding and a sequenced clear.
module param_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = (1 << ADDR_W) - 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_idx_s;
    logic              wr_ok_s;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we_s),
        .clr_idx  (clr_idx_s)
    );

    // clr_busy is high exactly when the sequencer is outside IDLE.
    assign wr_ok_s = wr_en && !clr_busy && (wr_addr != ZERO_IDX);

    // Storage: reset zeroes everything; the clear sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr_we_s) begin
            mem_r[clr_idx_s] <= '0;
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end else begin
            mem_r[wr_addr] <= mem_r[wr_addr];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        assign addr_s = rd_addr[p*ADDR_W +: ADDR_W];

        // Per-port read mux with zero-register override and optional forwarding.
        always_comb begin
            rd_data[p*DATA_W +: DATA_W] = mem_r[addr_s];
            if (addr_s == ZERO_IDX) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 32'sd0) && wr_ok_s && (wr_addr == addr_s)) begin
                rd_data[p*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data[p*DATA_W +: DATA_W] = mem_r[addr_s];
            end
        end
    end

endmodule

// File: tb/tb_param_regfile.sv
// Self-checking bench: three param_regfile configurations driven in lockstep
// and compared against an array-based reference model.
module tb_param_regfile;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         clr_req;
    logic [9:0]   rd_addr2;
    logic [19:0]  rd_addr4;
    logic [127:0] rd_data_a;
    logic [127:0] rd_data_b;
    logic [127:0] rd_data_c;
    logic         busy_a, busy_b, busy_c;
    logic         done_a, done_b, done_c;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    param_regfile dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr2), .rd_data(rd_data_a[127:0]),
        .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a)
    );

    param_regfile #(.BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr2), .rd_data(rd_data_b[127:0]),
        .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b)
    );

    param_regfile #(.DATA_W(32), .NUM_RD(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data[31:0]), .rd_addr(rd_addr4), .rd_data(rd_data_c[127:0]),
        .clr_req(clr_req), .clr_busy(busy_c), .clr_done(done_c)
    );

    // Reference model: plain register array plus clear progress counter
    // (-1 idle, 0..31 clearing that entry, 32 done cycle).
    logic [63:0] m_mem [32];
    int          cyc = -1;
    int          busy_seen = 0;
    int          done_seen = 0;

    function automatic logic [63:0] exp_rd(input int a, input bit byp);
        if (a == 31) return 64'd0;
        if (byp && cyc < 0 && wr_en && int'(wr_addr) == a) return wr_data;
        return m_mem[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rdA[%0d] a=%0d", p, rd_addr2[p*5 +: 5]), rd_data_a[p*64 +: 64],
                exp_rd(int'(rd_addr2[p*5 +: 5]), 1'b1));
            chk($sformatf("rdB[%0d] a=%0d", p, rd_addr2[p*5 +: 5]), rd_data_b[p*64 +: 64],
                exp_rd(int'(rd_addr2[p*5 +: 5]), 1'b0));
        end
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("rdC[%0d] a=%0d", p, rd_addr4[p*5 +: 5]), {32'd0, rd_data_c[p*32 +: 32]},
                {32'd0, exp_rd(int'(rd_addr4[p*5 +: 5]), 1'b1)} & 64'h0000_0000_FFFF_FFFF);
        end
        chk("busy", {61'd0, busy_a, busy_b, busy_c}, (cyc >= 0) ? 64'd7 : 64'd0);
        chk("done", {61'd0, done_a, done_b, done_c}, (cyc == 32) ? 64'd7 : 64'd0);
        if (busy_a) busy_seen++;
        if (done_a) done_seen++;
    endtask

    task automatic model_update();
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
            cyc = -1;
        end else if (cyc < 0) begin
            if (wr_en && wr_addr != 5'd31) m_mem[wr_addr] = wr_data;
            if (clr_req) cyc = 0;
        end else if (cyc < 32) begin
            m_mem[cyc] = 64'd0;
            cyc++;
        end else begin
            cyc = -1;
        end
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        reset_n  = 1'b1;
        wr_en    = 1'b0;
        clr_req  = 1'b0;
        wr_addr  = 5'($urandom);
        wr_data  = {$urandom, $urandom};
        rd_addr2 = 10'($urandom);
        rd_addr4 = 20'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
        quiet();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();

        // Write 0xDEADBEEF to r3, read on both ports the next cycle.
        quiet();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD_BEEF;
        step();
        quiet();
        rd_addr2 = {5'd3, 5'd3};
        #1;
        chk("r3 port0", rd_data_a[63:0], 64'hDEAD_BEEF);
        chk("r3 port1", rd_data_a[127:64], 64'hDEAD_BEEF);
        step();

        // Same-cycle forwarding vs pre-write value.
        quiet();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1234; rd_addr2 = {5'd5, 5'd5};
        #1;
        chk("bypass on", rd_data_a[63:0], 64'h1234);
        chk("bypass off", rd_data_b[63:0], 64'd0);
        step();

        // Writes to the zero register are discarded.
        quiet();
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF; rd_addr2 = {5'd31, 5'd31};
        step();
        quiet();
        rd_addr2 = {5'd31, 5'd31};
        step();

        // Fill every register.
        for (int i = 0; i < 32; i++) begin
            quiet();
            wr_en = 1'b1; wr_addr = 5'(i);
            step();
        end

        // Four ports: distinct and identical addresses.
        quiet();
        rd_addr4 = {5'd9, 5'd9, 5'd7, 5'd3};
        step();
        quiet();
        rd_addr4 = {5'd12, 5'd12, 5'd12, 5'd12};
        step();

        // Full clear with a dropped write at CLEAR cycle 10.
        busy_seen = 0; done_seen = 0;
        quiet();
        clr_req = 1'b1;
        step();
        for (int n = 0; n < 40; n++) begin
            quiet();
            if (cyc == 10) begin
                wr_en = 1'b1; wr_addr = 5'd2;
            end
            step();
        end
        chk("clear busy cycles", 64'(busy_seen), 64'd33);
        chk("clear done pulses", 64'(done_seen), 64'd1);
        for (int a = 0; a < 32; a++) begin
            quiet();
            rd_addr2 = {5'(a), 5'(a)};
            rd_addr4 = {4{5'(a)}};
            step();
        end

        // Reset at CLEAR cycle 7 aborts without a done pulse.
        for (int i = 0; i < 8; i++) begin
            quiet();
            wr_en = 1'b1;
            step();
        end
        quiet();
        clr_req = 1'b1;
        step();
        for (int n = 0; n < 20 && cyc != 7; n++) begin
            quiet();
            step();
        end
        chk("reached clear cycle 7", 64'(cyc), 64'd7);
        busy_seen = 0; done_seen = 0;
        quiet();
        reset_n = 1'b0;
        step();
        for (int n = 0; n < 40; n++) begin
            quiet();
            step();
        end
        chk("no done after abort", 64'(done_seen), 64'd0);

        // Held clear request plus a write in the same IDLE cycle.
        quiet();
        wr_en = 1'b1; wr_addr = 5'd4; clr_req = 1'b1;
        step();
        for (int n = 0; n < 70; n++) begin
            quiet();
            clr_req = 1'b1;
            step();
        end

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            quiet();
            reset_n = ($urandom_range(0, 149) != 0);
            wr_en   = $urandom_range(0, 2) != 0;
            clr_req = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) rd_addr2[4:0] = wr_addr;
            if ($urandom_range(0, 3) == 0) rd_addr4[14:10] = wr_addr;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
